// File: rtl/stencil_1d_ntap_pkg.sv
// -----------------------------------------------------------------------------
// stencil_pkg
// Shared types and helpers for the stencil_1d_ntap engine.
//   stencil_state_t : control FSM state encoding
//   ACC_MAX         : widest intermediate the saturation helper operates on
//   acc_width()     : full-precision accumulator width for WIDTH x TAPS
//   sat_clamp()     : clamp a signed value to a signed w-bit range
// -----------------------------------------------------------------------------
package stencil_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stencil_state_t;

  // Must exceed acc_width() for every instantiated configuration.
  localparam int ACC_MAX = 160;

  // Products are 2*WIDTH bits; summing TAPS of them needs clog2(TAPS) growth,
  // plus one guard bit so the sum can never wrap.
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps) + 1;
  endfunction

  function automatic logic signed [ACC_MAX-1:0] sat_clamp(
    input logic signed [ACC_MAX-1:0] v,
    input int                        w
  );
    logic signed [ACC_MAX-1:0] one;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/stencil_1d_ntap_if.sv
// -----------------------------------------------------------------------------
// stencil_1d_ntap_if
// memref_rd / memref_wr port pair between the stencil engine and its memories.
//   Ai_p0_* : read port of input memory A (data returns one cycle after rd_en)
//   Bw_p0_* : write port of output memory B
// Modports: master = engine side, slave = memory side.
// -----------------------------------------------------------------------------
interface stencil_1d_ntap_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);

  logic              Ai_p0_addr_en;
  logic [ADDR_W-1:0] Ai_p0_addr_data;
  logic              Ai_p0_rd_en;
  logic [WIDTH-1:0]  Ai_p0_rd_data;

  logic              Bw_p0_addr_en;
  logic [ADDR_W-1:0] Bw_p0_addr_data;
  logic              Bw_p0_wr_en;
  logic [WIDTH-1:0]  Bw_p0_wr_data;

  modport master (
    output Ai_p0_addr_en, Ai_p0_addr_data, Ai_p0_rd_en,
    input  Ai_p0_rd_data,
    output Bw_p0_addr_en, Bw_p0_addr_data, Bw_p0_wr_en, Bw_p0_wr_data
  );

  modport slave (
    input  Ai_p0_addr_en, Ai_p0_addr_data, Ai_p0_rd_en,
    output Ai_p0_rd_data,
    input  Bw_p0_addr_en, Bw_p0_addr_data, Bw_p0_wr_en, Bw_p0_wr_data
  );

endinterface

// File: rtl/stencil_1d_ntap_window.sv
// -----------------------------------------------------------------------------
// stencil_window
// TAPS-deep sliding window with multiply-add tree and registered result.
// Optional build macro: STENCIL_1D_SAT_EN (full-precision sum, clamped result);
// without it the result wraps mod 2^WIDTH.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : start of run, clears the fill counter
//   w_i          : packed weights, w[k] at [k*WIDTH +: WIDTH]
//   in_vld_i     : a sample is present on in_data_i
//   in_data_i    : returned sample
//   out_vld_o    : out_data_o holds a new result this cycle
//   out_data_o   : registered result
// -----------------------------------------------------------------------------
module stencil_window
  import stencil_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAPS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [TAPS*WIDTH-1:0] w_i,
  input  logic                  in_vld_i,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_vld_o,
  output logic [WIDTH-1:0]      out_data_o
);

`ifdef STENCIL_1D_SAT_EN
  localparam int CALC_W = acc_width(WIDTH, TAPS);
`else
  // Wrapping result only needs the low WIDTH bits of every product.
  localparam int CALC_W = WIDTH;
`endif
  localparam int FILL_W = $clog2(TAPS + 1);

  logic [WIDTH-1:0]         win_q [TAPS];
  logic [WIDTH-1:0]         win_d [TAPS];
  logic signed [CALC_W-1:0] prod  [TAPS];
  logic signed [CALC_W-1:0] sum;
  logic [FILL_W-1:0]        fill_q;
  logic                     full;
  logic                     fire;
  logic [WIDTH-1:0]         res_d;
  logic [WIDTH-1:0]         res_q;
  logic                     vld_q;

  // Fill saturates at TAPS-1: from then on every new sample completes a window.
  assign full = (fill_q == FILL_W'(TAPS - 1));
  assign fire = in_vld_i && full;

  // The result is computed from the window as it will look after this sample
  // shifts in, so it registers on the same edge as the shift.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic signed [CALC_W-1:0] w_ext;
    logic signed [CALC_W-1:0] d_ext;
    if (gi == TAPS - 1) begin : g_head
      assign win_d[gi] = in_data_i;
    end else begin : g_body
      assign win_d[gi] = win_q[gi+1];
    end
    assign w_ext    = CALC_W'($signed(w_i[gi*WIDTH +: WIDTH]));
    assign d_ext    = CALC_W'($signed(win_d[gi]));
    assign prod[gi] = w_ext * d_ext;
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + prod[k];
    end
  end

  always_comb begin
`ifdef STENCIL_1D_SAT_EN
    res_d = WIDTH'(sat_clamp(ACC_MAX'(sum), WIDTH));
`else
    res_d = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
      fill_q <= '0;
      res_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= fire;
      if (in_vld_i) begin
        for (int k = 0; k < TAPS; k++) win_q[k] <= win_d[k];
      end
      if (fire) res_q <= res_d;
      if (clr_i)                 fill_q <= '0;
      else if (in_vld_i && !full) fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign out_vld_o  = vld_q;
  assign out_data_o = res_q;

endmodule

// File: rtl/stencil_1d_ntap.sv
// -----------------------------------------------------------------------------
// stencil_1d_ntap
// N-tap 1D stencil engine: B[i] = sum_k w[k]*A[i+k], i = 0..DEPTH-TAPS.
// Streams A[0..DEPTH-1], one read per cycle, one result write per cycle.
// Optional build macro: STENCIL_1D_SAT_EN (saturating result, see window).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   t        : start pulse (accepted only in IDLE)
//   w        : packed weights, latched at an accepted t
//   mem      : memref read/write port pair (master side)
//   busy     : run in progress (READ and DRAIN)
//   done     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module stencil_1d_ntap
  import stencil_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int TAPS   = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  t,
  input  logic [TAPS*WIDTH-1:0] w,
  stencil_1d_ntap_if.master     mem,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  stencil_state_t        state_q, state_d;
  logic [ADDR_W-1:0]     rd_cnt_q;
  logic                  drain_q;
  logic [TAPS*WIDTH-1:0] w_q;
  logic                  rd_vld_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic                  start;
  logic                  rd_en;
  logic                  out_vld;
  logic [WIDTH-1:0]      out_data;

  assign start = (state_q == IDLE) && t;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (t) state_d = READ;
      READ:    if (rd_cnt_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state_q == READ) || (state_q == DRAIN);
    done  = (state_q == DONE);
    rd_en = (state_q == READ);
  end

  // Counters, weight latch and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      drain_q   <= 1'b0;
      w_q       <= '0;
      rd_vld_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      // Memory data is valid exactly one cycle after the strobe.
      rd_vld_q <= rd_en;
      // drain_q marks the second DRAIN cycle.
      drain_q  <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      if (start) begin
        rd_cnt_q  <= '0;
        w_q       <= w;
        wr_addr_q <= '0;
      end else begin
        if (rd_en && (rd_cnt_q != LAST_ADDR)) rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
        if (out_vld) wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
    end
  end

  stencil_window #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start),
    .w_i        (w_q),
    .in_vld_i   (rd_vld_q),
    .in_data_i  (mem.Ai_p0_rd_data),
    .out_vld_o  (out_vld),
    .out_data_o (out_data)
  );

  // Addresses are forced to 0 whenever their strobe is low.
  assign mem.Ai_p0_rd_en     = rd_en;
  assign mem.Ai_p0_addr_en   = rd_en;
  assign mem.Ai_p0_addr_data = rd_en ? rd_cnt_q : '0;
  assign mem.Bw_p0_wr_en     = out_vld;
  assign mem.Bw_p0_addr_en   = out_vld;
  assign mem.Bw_p0_addr_data = out_vld ? wr_addr_q : '0;
  assign mem.Bw_p0_wr_data   = out_data;

endmodule
